// File: rtl/lamp_input_bank_if.sv
// Bus between the lamp input bank and its driver/evaluator side.
// The bank side uses modport slave; the wire/evaluator side uses modport master.
interface lamp_input_bank_if #(
    parameter int unsigned LAMP_COUNT = 2,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic [LAMP_COUNT-1:0] wire_pulse;
    logic                  frame_end;
    logic [LAMP_COUNT-1:0] lamp_state;
    logic                  snap_valid;
    logic [LAMP_COUNT-1:0] snap_data;
    logic                  snap_ready;
    logic [CNT_WIDTH-1:0]  coalesce_cnt;

    modport master (
        output wire_pulse, frame_end, snap_ready,
        input  lamp_state, snap_valid, snap_data, coalesce_cnt
    );

    modport slave (
        input  wire_pulse, frame_end, snap_ready,
        output lamp_state, snap_valid, snap_data, coalesce_cnt
    );
endinterface

// File: rtl/lamp_input_bank.sv
// Toggles lamp levels from wire pulses and offers a snapshot per changed frame
// over valid/ready, coalescing frames that end while an offer is still pending.
module lamp_input_bank #(
    parameter int unsigned LAMP_COUNT = 2,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic               clk,
    input logic               logic_reset,
    lamp_input_bank_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [LAMP_COUNT-1:0] lamp_state;
    logic [LAMP_COUNT-1:0] last_sent;
    logic [LAMP_COUNT-1:0] frame_latch;
    logic [LAMP_COUNT-1:0] snap_data;
    logic [LAMP_COUNT-1:0] lamps_next;
    logic [LAMP_COUNT-1:0] load_val;
    logic                  snap_valid;
    logic                  xfer;
    logic                  load;
    logic                  latch_en;
    logic                  cnt_inc;
    logic [CNT_WIDTH-1:0]  coalesce_cnt;

    always_comb begin
        lamps_next = lamp_state ^ bus.wire_pulse;
        xfer       = snap_valid && bus.snap_ready;
        state_next = state;
        load       = 1'b0;
        load_val   = lamps_next;
        latch_en   = 1'b0;
        cnt_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.frame_end && (lamps_next != last_sent)) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    if (bus.frame_end && (lamps_next != last_sent)) begin
                        load       = 1'b1;
                        state_next = HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bus.frame_end && (lamps_next != last_sent)) begin
                    latch_en   = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (xfer) begin
                    // A frame ending on the transfer cycle supersedes the latched one.
                    load_val = bus.frame_end ? lamps_next : frame_latch;
                    if (load_val != last_sent) begin
                        load       = 1'b1;
                        state_next = HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bus.frame_end) begin
                    latch_en = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (logic_reset) begin
            state        <= IDLE;
            lamp_state   <= '0;
            last_sent    <= '0;
            frame_latch  <= '0;
            snap_data    <= '0;
            snap_valid   <= 1'b0;
            coalesce_cnt <= '0;
        end else begin
            state      <= state_next;
            lamp_state <= lamps_next;
            // Registered copy of the offer flag keeps snap_valid a pure flop output.
            snap_valid <= (state_next != IDLE);
            if (load) begin
                snap_data <= load_val;
                last_sent <= load_val;
            end
            if (latch_en) begin
                frame_latch <= lamps_next;
            end
            if (cnt_inc && (coalesce_cnt != '1)) begin
                coalesce_cnt <= coalesce_cnt + 1'b1;
            end
        end
    end

    assign bus.lamp_state   = lamp_state;
    assign bus.snap_valid   = snap_valid;
    assign bus.snap_data    = snap_data;
    assign bus.coalesce_cnt = coalesce_cnt;
endmodule

// File: tb/tb_lamp_input_bank.sv
// Bench for lamp_input_bank: directed vector table, saturation sequence,
// then random traffic against a queue-based reference model.
module tb_lamp_input_bank;
    localparam int unsigned LC   = 2;
    localparam int unsigned CW   = 2;
    localparam int          MAXC = (1 << CW) - 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lamp_input_bank_if #(.LAMP_COUNT(LC), .CNT_WIDTH(CW)) bus ();

    lamp_input_bank #(.LAMP_COUNT(LC), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .logic_reset (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [LC-1:0] pulse;
        logic          fe;
        logic          rdy;
        logic [LC-1:0] lamp;
        logic          valid;
        logic [LC-1:0] data;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[$];

    // Reference model: an offer slot plus at most one waiting frame.
    logic [LC-1:0] m_lamp, m_last, m_data;
    logic          m_valid;
    logic [LC-1:0] m_pend[$];
    int            m_cnt;

    task automatic model_step(input logic r, input logic [LC-1:0] p, input logic fe, input logic rdy);
        logic [LC-1:0] newv, cand;
        logic          has;
        if (r) begin
            m_lamp = '0; m_last = '0; m_data = '0; m_valid = 1'b0; m_cnt = 0;
            m_pend.delete();
            return;
        end
        newv = m_lamp ^ p;
        if (m_valid && rdy) begin
            has  = 1'b0;
            cand = '0;
            if (fe) begin
                has = 1'b1; cand = newv;
            end else if (m_pend.size() > 0) begin
                has = 1'b1; cand = m_pend[0];
            end
            m_pend.delete();
            m_valid = 1'b0;
            if (has && cand != m_last) begin
                m_valid = 1'b1; m_data = cand; m_last = cand;
            end
        end else if (fe) begin
            if (m_pend.size() > 0) begin
                m_pend[0] = newv;
                if (m_cnt < MAXC) m_cnt++;
            end else if (newv != m_last) begin
                if (m_valid) m_pend.push_back(newv);
                else begin
                    m_valid = 1'b1; m_data = newv; m_last = newv;
                end
            end
        end
        m_lamp = newv;
    endtask

    task automatic step(input logic r, input logic [LC-1:0] p, input logic fe, input logic rdy);
        rst            = r;
        bus.wire_pulse = p;
        bus.frame_end  = fe;
        bus.snap_ready = rdy;
        model_step(r, p, fe, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [LC-1:0] lamp, input logic valid,
                           input logic [LC-1:0] data, input int cnt);
        chk({tag, "_lamp"},  int'(bus.lamp_state),   int'(lamp));
        chk({tag, "_valid"}, int'(bus.snap_valid),   int'(valid));
        chk({tag, "_data"},  int'(bus.snap_data),    int'(data));
        chk({tag, "_cnt"},   int'(bus.coalesce_cnt), cnt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; bus.wire_pulse = '0; bus.frame_end = 1'b0; bus.snap_ready = 1'b0;
        step(1'b1, 2'b00, 1'b0, 1'b0);
        chk_all("reset", 2'b00, 1'b0, 2'b00, 0);

        // rst pulse fe rdy | lamp valid data cnt
        // single pulse, frame, accept
        tbl.push_back('{1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'd0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'd0});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 2'd0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 2'd0});
        // no-change frame
        tbl.push_back('{1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 2'd0});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 2'd0});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b01, 2'd0});
        // back-pressure coalescing 01,11,10
        tbl.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'd0});
        tbl.push_back('{1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 2'd0});
        tbl.push_back('{1'b0, 2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 2'd0});
        tbl.push_back('{1'b0, 2'b01, 1'b1, 1'b0, 2'b10, 1'b1, 2'b01, 2'd1});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'd1});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b10, 2'd1});
        // reverted pending change: hold 11, frames 01 then 11
        tbl.push_back('{1'b0, 2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b11, 2'd1});
        tbl.push_back('{1'b0, 2'b10, 1'b1, 1'b0, 2'b01, 1'b1, 2'b11, 2'd1});
        tbl.push_back('{1'b0, 2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 2'b11, 2'd2});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b11, 2'd2});
        // frame_end on the transfer cycle in PEND
        tbl.push_back('{1'b0, 2'b01, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'd2});
        tbl.push_back('{1'b0, 2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'd2});
        tbl.push_back('{1'b0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 2'd2});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 2'd2});
        // reach cnt=3 with an offer pending, then reset over busy inputs
        tbl.push_back('{1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 2'd2});
        tbl.push_back('{1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 2'd2});
        tbl.push_back('{1'b0, 2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 2'd3});
        tbl.push_back('{1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].pulse, tbl[i].fe, tbl[i].rdy);
            chk_all($sformatf("vec%0d", i), tbl[i].lamp, tbl[i].valid, tbl[i].data, int'(tbl[i].cnt));
        end

        // Saturation: five coalesced frames must stop at the counter maximum.
        step(1'b0, 2'b01, 1'b1, 1'b0);
        step(1'b0, 2'b10, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 2'b01, 1'b1, 1'b0);
            chk($sformatf("sat%0d_cnt", k), int'(bus.coalesce_cnt), (k < MAXC) ? k : MAXC);
        end
        chk("sat_valid", int'(bus.snap_valid), 1);
        chk("sat_data",  int'(bus.snap_data),  1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        chk_all("sat_rel", 2'b10, 1'b1, 2'b10, MAXC);

        // Random traffic against the model.
        step(1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic          r, fe, rdy;
            logic [LC-1:0] p;
            r   = ($urandom_range(0, 99) == 0);
            p   = LC'($urandom);
            fe  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 1) == 0);
            step(r, p, fe, rdy);
            chk_all($sformatf("rnd%0d", i), m_lamp, m_valid, m_data, m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
